// File: rtl/yavas_sayac_pkg.sv
// Shared constants and helpers for the parametrised slow up/down counter.
package yavas_sayac_pkg;

  localparam logic MOD_SARMA  = 1'b0;
  localparam logic MOD_DOYMA  = 1'b1;
  localparam logic YON_YUKARI = 1'b1;
  localparam logic YON_ASAGI  = 1'b0;

  // What the counter register does on a given edge, in priority order.
  typedef enum logic [1:0] {
    ISLEM_BEKLE = 2'd0,
    ISLEM_YUKLE = 2'd1,
    ISLEM_ADIM  = 2'd2
  } islem_e;

  // Bits needed to hold 0..n-1; never less than one so a divide-by-one still has a register.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/yavas_sayac_param_on_bolucu.sv
// Enable-gated prescaler: counts 0..BOLME-1 and flags the last enabled clock of each period.
module on_bolucu
  import yavas_sayac_pkg::*;
#(
  parameter int BOLME = 4
) (
  input  logic clk,
  input  logic sifirlama,
  input  logic etkin,
  input  logic temizle,
  output logic tik
);

  localparam int W = clog2(BOLME);
  localparam logic [W-1:0] SON = W'(BOLME - 1);

  logic [W-1:0] sayim_q;
  logic [W-1:0] sayim_d;

  assign tik = etkin && (sayim_q == SON);

  always_comb begin
    // NOTE: assign a default before any branch so always_comb never infers a latch.
    sayim_d = sayim_q;
    if (temizle) begin
      sayim_d = '0;
    end else if (tik) begin
      sayim_d = '0;
    end else if (etkin) begin
      sayim_d = sayim_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (sifirlama) begin
      sayim_q <= '0;
    end else begin
      sayim_q <= sayim_d;
    end
  end

endmodule

// File: rtl/yavas_sayac_param.sv
// Slow up/down counter with prescaler, runtime step, wrap/saturate at UST_SINIR and load.
module yavas_sayac_param
  import yavas_sayac_pkg::*;
#(
  parameter int GENISLIK      = 6,
  parameter int ADIM_GENISLIK = 3,
  parameter int BOLME         = 4,
  parameter int UST_SINIR     = 63
) (
  input  logic                     clk,
  input  logic                     sifirlama,
  input  logic                     etkin,
  input  logic                     sayma_yonu,
  input  logic [ADIM_GENISLIK-1:0] sayma_miktari,
  input  logic                     mod_sec,
  input  logic                     yukle,
  input  logic [GENISLIK-1:0]      yukle_deger,
  output logic [GENISLIK-1:0]      sayac_out,
  output logic                     adim_tik,
  output logic                     tasma
);

  if (UST_SINIR > (2 ** GENISLIK) - 1) begin : g_ust_sinir_hatasi
    $fatal(1, "UST_SINIR does not fit in GENISLIK bits");
  end
  if ((2 ** ADIM_GENISLIK) - 1 > UST_SINIR) begin : g_adim_hatasi
    $fatal(1, "largest step exceeds UST_SINIR");
  end
  if (BOLME < 1) begin : g_bolme_hatasi
    $fatal(1, "BOLME must be at least 1");
  end

  // One extra bit so c+k and c+M-k never lose their carry.
  localparam int GW = GENISLIK + 1;
  localparam logic [GENISLIK:0] UST_G = GW'(UST_SINIR);
  localparam logic [GENISLIK:0] MOD_G = GW'(UST_SINIR + 1);

  logic                tik;
  logic [GENISLIK-1:0] sayac_q, sayac_d;
  logic                adim_tik_q, adim_tik_d;
  logic                tasma_q, tasma_d;

  islem_e              islem;
  logic [GENISLIK:0]   c_g, k_g, yuk_g;
  logic [GENISLIK:0]   toplam, fark, sarma_asagi, adim_sonuc;
  logic [GENISLIK:0]   yuklenecek;
  logic                yukari_tasti, asagi_tasti, adim_tasma;

  on_bolucu #(
    .BOLME(BOLME)
  ) u_on_bolucu (
    .clk      (clk),
    .sifirlama(sifirlama),
    .etkin    (etkin),
    .temizle  (yukle),
    .tik      (tik)
  );

  always_comb begin
    islem = ISLEM_BEKLE;
    if (yukle) begin
      islem = ISLEM_YUKLE;
    end else if (tik) begin
      islem = ISLEM_ADIM;
    end
  end

  always_comb begin
    c_g          = {1'b0, sayac_q};
    k_g          = GW'(sayma_miktari);
    yuk_g        = {1'b0, yukle_deger};
    toplam       = c_g + k_g;
    fark         = c_g - k_g;
    sarma_asagi  = c_g + MOD_G - k_g;
    yukari_tasti = (toplam > UST_G);
    asagi_tasti  = (k_g > c_g);
    yuklenecek   = (yuk_g > UST_G) ? UST_G : yuk_g;

    adim_sonuc = c_g;
    adim_tasma = 1'b0;
    if (sayma_yonu == YON_YUKARI) begin
      if (yukari_tasti) begin
        adim_sonuc = (mod_sec == MOD_DOYMA) ? UST_G : (toplam - MOD_G);
        adim_tasma = 1'b1;
      end else begin
        adim_sonuc = toplam;
      end
    end else begin
      // Saturating at zero when already at zero also lands here and still raises tasma.
      if (asagi_tasti) begin
        adim_sonuc = (mod_sec == MOD_DOYMA) ? '0 : sarma_asagi;
        adim_tasma = 1'b1;
      end else begin
        adim_sonuc = fark;
      end
    end
  end

  always_comb begin
    sayac_d    = sayac_q;
    adim_tik_d = 1'b0;
    tasma_d    = 1'b0;
    unique case (islem)
      ISLEM_YUKLE: sayac_d = GENISLIK'(yuklenecek);
      ISLEM_ADIM: begin
        sayac_d    = GENISLIK'(adim_sonuc);
        adim_tik_d = 1'b1;
        tasma_d    = adim_tasma;
      end
      default: sayac_d = sayac_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sifirlama) begin
      sayac_q    <= '0;
      adim_tik_q <= 1'b0;
      tasma_q    <= 1'b0;
    end else begin
      sayac_q    <= sayac_d;
      adim_tik_q <= adim_tik_d;
      tasma_q    <= tasma_d;
    end
  end

  assign sayac_out = sayac_q;
  assign adim_tik  = adim_tik_q;
  assign tasma     = tasma_q;

endmodule

// File: tb/tb_yavas_sayac_param.sv
// Directed bench for yavas_sayac_param: default build, a 4-bit/bound-9 build and a 7-bit build.
module tb_yavas_sayac_param;

  logic       clk;
  logic       sifirlama;
  logic       etkin;
  logic       yon;
  logic [2:0] miktar;
  logic       mod_s;
  logic       yukle;
  logic [5:0] deger_a;
  logic [3:0] deger_b;
  logic [6:0] deger_c;
  logic [5:0] sayac_a;
  logic [3:0] sayac_b;
  logic [6:0] sayac_c;
  logic       tik_a, tik_b, tik_c;
  logic       tas_a, tas_b, tas_c;

  int total = 0;
  int bad   = 0;

  yavas_sayac_param #(
    .GENISLIK(6), .ADIM_GENISLIK(3), .BOLME(4), .UST_SINIR(63)
  ) dut_a (
    .clk(clk), .sifirlama(sifirlama), .etkin(etkin), .sayma_yonu(yon),
    .sayma_miktari(miktar), .mod_sec(mod_s), .yukle(yukle), .yukle_deger(deger_a),
    .sayac_out(sayac_a), .adim_tik(tik_a), .tasma(tas_a)
  );

  yavas_sayac_param #(
    .GENISLIK(4), .ADIM_GENISLIK(3), .BOLME(1), .UST_SINIR(9)
  ) dut_b (
    .clk(clk), .sifirlama(sifirlama), .etkin(etkin), .sayma_yonu(yon),
    .sayma_miktari(miktar), .mod_sec(mod_s), .yukle(yukle), .yukle_deger(deger_b),
    .sayac_out(sayac_b), .adim_tik(tik_b), .tasma(tas_b)
  );

  yavas_sayac_param #(
    .GENISLIK(7), .ADIM_GENISLIK(3), .BOLME(4), .UST_SINIR(63)
  ) dut_c (
    .clk(clk), .sifirlama(sifirlama), .etkin(etkin), .sayma_yonu(yon),
    .sayma_miktari(miktar), .mod_sec(mod_s), .yukle(yukle), .yukle_deger(deger_c),
    .sayac_out(sayac_c), .adim_tik(tik_c), .tasma(tas_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic saat(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    sifirlama = 1'b1;
    saat(2);
    total++; if (sayac_a !== 6'd0) begin bad++; $display("FAIL reset_sayac_a: got %0d want 0", sayac_a); end
    total++; if (tik_a !== 1'b0) begin bad++; $display("FAIL reset_tik_a: got %b want 0", tik_a); end
    total++; if (tas_a !== 1'b0) begin bad++; $display("FAIL reset_tas_a: got %b want 0", tas_a); end
    total++; if (sayac_b !== 4'd0) begin bad++; $display("FAIL reset_sayac_b: got %0d want 0", sayac_b); end
    total++; if (sayac_c !== 7'd0) begin bad++; $display("FAIL reset_sayac_c: got %0d want 0", sayac_c); end
  endtask

  task automatic test_up_wrap();
    int exp_v;
    sifirlama = 1'b0; etkin = 1'b1; yon = 1'b1; miktar = 3'd5; mod_s = 1'b0;
    for (int u = 1; u <= 13; u++) begin
      for (int s = 0; s < 3; s++) begin
        saat(1);
        total++; if (tik_a !== 1'b0 || tas_a !== 1'b0) begin bad++; $display("FAIL up_ara_pulse u=%0d: got tik=%b tas=%b want 0 0", u, tik_a, tas_a); end
      end
      saat(1);
      exp_v = (u == 13) ? 1 : 5 * u;
      total++; if (sayac_a !== 6'(exp_v)) begin bad++; $display("FAIL up_sayac u=%0d: got %0d want %0d", u, sayac_a, exp_v); end
      total++; if (tik_a !== 1'b1) begin bad++; $display("FAIL up_tik u=%0d: got %b want 1", u, tik_a); end
      total++; if (tas_a !== (u == 13)) begin bad++; $display("FAIL up_tasma u=%0d: got %b want %b", u, tas_a, (u == 13)); end
    end
  endtask

  task automatic test_down();
    yukle = 1'b1; deger_a = 6'd2; yon = 1'b0; miktar = 3'd3; mod_s = 1'b0;
    saat(1);
    yukle = 1'b0;
    total++; if (sayac_a !== 6'd2 || tik_a !== 1'b0) begin bad++; $display("FAIL down_load: got %0d tik=%b want 2 tik=0", sayac_a, tik_a); end
    saat(3);
    total++; if (tik_a !== 1'b0) begin bad++; $display("FAIL down_ara_tik: got %b want 0", tik_a); end
    saat(1);
    // 2 - 3 modulo 64.
    total++; if (sayac_a !== 6'd63 || tas_a !== 1'b1) begin bad++; $display("FAIL down_wrap: got %0d tas=%b want 63 tas=1", sayac_a, tas_a); end
    yukle = 1'b1; deger_a = 6'd2; mod_s = 1'b1;
    saat(1);
    yukle = 1'b0;
    saat(4);
    total++; if (sayac_a !== 6'd0 || tas_a !== 1'b1) begin bad++; $display("FAIL down_sat: got %0d tas=%b want 0 tas=1", sayac_a, tas_a); end
    saat(4);
    total++; if (sayac_a !== 6'd0 || tas_a !== 1'b1 || tik_a !== 1'b1) begin bad++; $display("FAIL down_sat_tekrar: got %0d tas=%b tik=%b want 0 1 1", sayac_a, tas_a, tik_a); end
  endtask

  task automatic test_sat_up();
    yukle = 1'b1; deger_a = 6'd60; yon = 1'b1; miktar = 3'd7; mod_s = 1'b1;
    saat(1);
    yukle = 1'b0;
    saat(4);
    total++; if (sayac_a !== 6'd63 || tas_a !== 1'b1) begin bad++; $display("FAIL sat_up: got %0d tas=%b want 63 tas=1", sayac_a, tas_a); end
    miktar = 3'd0;
    saat(4);
    total++; if (sayac_a !== 6'd63 || tik_a !== 1'b1 || tas_a !== 1'b0) begin bad++; $display("FAIL sat_k0: got %0d tik=%b tas=%b want 63 1 0", sayac_a, tik_a, tas_a); end
  endtask

  task automatic test_pause();
    yukle = 1'b1; deger_a = 6'd0; yon = 1'b1; miktar = 3'd5; mod_s = 1'b0;
    saat(1);
    yukle = 1'b0;
    saat(2);
    etkin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      saat(1);
      total++; if (sayac_a !== 6'd0 || tik_a !== 1'b0 || tas_a !== 1'b0) begin bad++; $display("FAIL pause_hold i=%0d: got %0d tik=%b tas=%b want 0 0 0", i, sayac_a, tik_a, tas_a); end
    end
    etkin = 1'b1;
    saat(1);
    total++; if (sayac_a !== 6'd0 || tik_a !== 1'b0) begin bad++; $display("FAIL pause_resume1: got %0d tik=%b want 0 0", sayac_a, tik_a); end
    saat(1);
    total++; if (sayac_a !== 6'd5 || tik_a !== 1'b1) begin bad++; $display("FAIL pause_resume2: got %0d tik=%b want 5 1", sayac_a, tik_a); end
  endtask

  task automatic test_same_edge();
    saat(3);
    sifirlama = 1'b1; yukle = 1'b1; deger_a = 6'd17;
    saat(1);
    total++; if (sayac_a !== 6'd0 || tik_a !== 1'b0 || tas_a !== 1'b0) begin bad++; $display("FAIL rst_load_tick: got %0d tik=%b tas=%b want 0 0 0", sayac_a, tik_a, tas_a); end
    sifirlama = 1'b0; yukle = 1'b0;
    saat(4);
    total++; if (sayac_a !== 6'd5 || tik_a !== 1'b1) begin bad++; $display("FAIL after_rst_update: got %0d tik=%b want 5 1", sayac_a, tik_a); end
    saat(3);
    yukle = 1'b1; deger_a = 6'd17;
    saat(1);
    yukle = 1'b0;
    total++; if (sayac_a !== 6'd17 || tik_a !== 1'b0 || tas_a !== 1'b0) begin bad++; $display("FAIL load_on_tick: got %0d tik=%b tas=%b want 17 0 0", sayac_a, tik_a, tas_a); end
    saat(3);
    total++; if (sayac_a !== 6'd17 || tik_a !== 1'b0) begin bad++; $display("FAIL load_ara: got %0d tik=%b want 17 0", sayac_a, tik_a); end
    saat(1);
    total++; if (sayac_a !== 6'd22 || tik_a !== 1'b1) begin bad++; $display("FAIL load_next_update: got %0d tik=%b want 22 1", sayac_a, tik_a); end
    yukle = 1'b1; deger_c = 7'd70; deger_b = 4'd12; deger_a = 6'd63;
    saat(1);
    yukle = 1'b0;
    total++; if (sayac_c !== 7'd63) begin bad++; $display("FAIL load_clip_c: got %0d want 63", sayac_c); end
    total++; if (sayac_b !== 4'd9) begin bad++; $display("FAIL load_clip_b: got %0d want 9", sayac_b); end
    total++; if (sayac_a !== 6'd63) begin bad++; $display("FAIL load_max_a: got %0d want 63", sayac_a); end
  endtask

  task automatic test_small_bound();
    int exp_b[4];
    exp_b = '{3, 6, 9, 2};
    sifirlama = 1'b1;
    saat(1);
    sifirlama = 1'b0; etkin = 1'b1; yon = 1'b1; miktar = 3'd3; mod_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saat(1);
      total++; if (sayac_b !== 4'(exp_b[i])) begin bad++; $display("FAIL small_sayac i=%0d: got %0d want %0d", i, sayac_b, exp_b[i]); end
      total++; if (tik_b !== 1'b1) begin bad++; $display("FAIL small_tik i=%0d: got %b want 1", i, tik_b); end
      total++; if (tas_b !== (i == 3)) begin bad++; $display("FAIL small_tasma i=%0d: got %b want %b", i, tas_b, (i == 3)); end
    end
  endtask

  initial begin
    sifirlama = 1'b1; etkin = 1'b0; yon = 1'b1; miktar = '0; mod_s = 1'b0;
    yukle = 1'b0; deger_a = '0; deger_b = '0; deger_c = '0;
    test_reset();
    test_up_wrap();
    test_down();
    test_sat_up();
    test_pause();
    test_same_edge();
    test_small_bound();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
